// File: rtl/boost_pkg.sv
// Shared types and widths for the boost duty-cycle controller.
package boost_pkg;
  localparam int ADC_W  = 12;
  localparam int ERR_W  = 13;
  localparam int PROD_W = 21;
  localparam int ACC_W  = 24;
  localparam int DUTY_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERR,
    S_INTEG,
    S_OUT
  } state_t;
endpackage

// File: rtl/boost_duty_ctrl_pi_sat.sv
// pi_sat: y = clamp((base + e*GAIN) >>> SHIFT, LO, HI), purely combinational.
module pi_sat
  import boost_pkg::*;
#(
  parameter int GAIN  = 16,
  parameter int SHIFT = 8,
  parameter int LO    = 0,
  parameter int HI    = 900,
  parameter int E_W   = ERR_W,
  parameter int P_W   = PROD_W,
  parameter int A_W   = ACC_W,
  parameter int OUT_W = DUTY_W
) (
  input  logic [E_W-1:0]   e,
  input  logic [A_W-1:0]   base,
  output logic [OUT_W-1:0] y
);
  // One guard bit so base + product can never wrap before clamping.
  localparam int S_W = A_W + 1;
  localparam logic [7:0] GAIN8 = 8'(GAIN);
  localparam logic signed [S_W-1:0] LO_S = S_W'(LO);
  localparam logic signed [S_W-1:0] HI_S = S_W'(HI);

  logic signed [P_W-1:0] e_x, g_x, prod;
  logic signed [S_W-1:0] sum, shifted, sat;

  assign e_x     = P_W'($signed(e));
  assign g_x     = P_W'({1'b0, GAIN8});
  assign prod    = e_x * g_x;
  assign sum     = S_W'($signed(base)) + S_W'(prod);
  assign shifted = sum >>> SHIFT;

  always_comb begin
    sat = shifted;
    if (shifted < LO_S)      sat = LO_S;
    else if (shifted > HI_S) sat = HI_S;
  end

  assign y = sat[OUT_W-1:0];
endmodule

// File: rtl/boost_duty_ctrl.sv
// Saturating PI duty controller for the boost PWM, one update per clk_int tick.
// Optional duty slew limiting is compiled in with BOOST_DUTY_SLEW_EN.
module boost_duty_ctrl
  import boost_pkg::*;
#(
  parameter int KP        = 16,
  parameter int KI        = 2,
  parameter int FRAC      = 8,
  parameter int D_MIN     = 0,
  parameter int D_MAX     = 900,
  parameter int TIMEOUT   = 1000,
  parameter int SLEW_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              tick,
  input  logic [ADC_W-1:0]  v_ref,
  input  logic [ADC_W-1:0]  v_meas,
  input  logic              v_valid,
  output logic [DUTY_W-1:0] d_boost,
  output logic              d_valid,
  output logic              overrun,
  output logic              timeout
);
  localparam int ACC_LO = D_MIN << FRAC;
  localparam int ACC_HI = D_MAX << FRAC;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic signed [ACC_W-1:0] ACC_RST = ACC_W'(ACC_LO);
  localparam logic [CNT_W-1:0]        CNT_END = CNT_W'(TIMEOUT - 1);

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [ADC_W-1:0]          v_meas_q;
  logic signed [ERR_W-1:0]   e_q;
  logic signed [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]          acc_nxt;
  logic [DUTY_W-1:0]         u, d_new;
  logic [2:0]                tick_sync;
  logic                      tick_re;

  // tick is asynchronous: two sync stages, third stage is the edge reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_sync <= '0;
    else        tick_sync <= {tick_sync[1:0], tick};
  end
  assign tick_re = tick_sync[1] & ~tick_sync[2];

  pi_sat #(
    .GAIN(KI), .SHIFT(0), .LO(ACC_LO), .HI(ACC_HI), .OUT_W(ACC_W)
  ) u_integ (
    .e(e_q), .base(acc), .y(acc_nxt)
  );

  // OUT sees the accumulator already updated in INTEG.
  pi_sat #(
    .GAIN(KP), .SHIFT(FRAC), .LO(D_MIN), .HI(D_MAX), .OUT_W(DUTY_W)
  ) u_out (
    .e(e_q), .base(acc), .y(u)
  );

`ifdef BOOST_DUTY_SLEW_EN
  // Result lies between d_boost and u, both in bounds, so bounds still hold.
  logic [DUTY_W:0] d_x, u_x, up_lim;
  always_comb begin
    d_x    = {1'b0, d_boost};
    u_x    = {1'b0, u};
    up_lim = d_x + (DUTY_W+1)'(SLEW_STEP);
    d_new  = u;
    if (u_x > up_lim)
      d_new = up_lim[DUTY_W-1:0];
    else if (u_x + (DUTY_W+1)'(SLEW_STEP) < d_x)
      d_new = d_boost - DUTY_W'(SLEW_STEP);
  end
`else
  assign d_new = u;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      v_meas_q <= '0;
      e_q      <= '0;
      acc      <= ACC_RST;
      d_boost  <= '0;
      d_valid  <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else if (!ce) begin
      state   <= S_IDLE;
      acc     <= ACC_RST;
      d_boost <= '0;
      d_valid <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      d_valid <= 1'b0;
      if (tick_re && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: if (tick_re) begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Timeout is checked first so a coincident v_valid loses.
          if (cnt == CNT_END) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else if (v_valid) begin
            v_meas_q <= v_meas;
            state    <= S_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ERR: begin
          e_q   <= $signed({1'b0, v_ref}) - $signed({1'b0, v_meas_q});
          state <= S_INTEG;
        end
        S_INTEG: begin
          acc   <= $signed(acc_nxt);
          state <= S_OUT;
        end
        S_OUT: begin
          d_boost <= d_new;
          d_valid <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_boost_duty_ctrl.sv
// Scoreboard bench for boost_duty_ctrl: stimulus queues expected duty/cycle, monitor checks on d_valid.
module tb_boost_duty_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, ce, tick, v_valid;
  logic [11:0] v_ref, v_meas;
  logic [9:0]  d_boost;
  logic        d_valid, overrun, timeout;

  typedef struct {
    int d;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  boost_duty_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .tick(tick),
    .v_ref(v_ref), .v_meas(v_meas), .v_valid(v_valid),
    .d_boost(d_boost), .d_valid(d_valid), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every d_valid pulse must match the head of the queue in value and cycle.
  always @(negedge clk) begin
    if (rst_n && d_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_d_valid: got d_boost %0d, expected no update (cycle %0d)", d_boost, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("d_boost", int'(d_boost), e.d);
        chk("d_latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    wait_n(10);
    tick = 1'b0;
  endtask

  // Tick, then the sample 100 clk later; update expected 3 clk after the v_valid cycle.
  task automatic update(input int vm, input int exp_d);
    pulse_tick();
    wait_n(90);
    v_meas  = 12'(vm);
    v_valid = 1'b1;
    q.push_back('{exp_d, cyc + 4});
    wait_n(1);
    v_valid = 1'b0;
    wait_n(10);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion, expected finish within 5 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ce = 1'b0; tick = 1'b0; v_valid = 1'b0;
    v_ref = 12'd2000; v_meas = 12'd0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(1);
    chk("rst_d_boost", int'(d_boost), 0);
    chk("rst_d_valid", int'(d_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_timeout", int'(timeout), 0);
    ce = 1'b1;
    wait_n(3);

    // e = 100: acc 200/400/600 -> u 7, 7, 8
    update(1900, 7);
    update(1900, 7);
    update(1900, 8);

    // e = 4095: acc_k = 600 + 8190k, u_k = (66120 + 8190k) >> 8, capped at 900
    v_ref = 12'd4095;
    for (int k = 1; k <= 32; k++) begin
      int u;
      u = (66120 + 8190 * k) / 256;
      update(0, (u > 900) ? 900 : u);
    end

    // e = -100 from acc clamped at 230400: (230200 - 1600) >> 8 = 892
    v_ref = 12'd2000;
    update(2100, 892);

    // Missing sample: timeout fires 1000 clk into WAIT_SAMPLE, duty untouched
    tick = 1'b1;
    wait_n(10);
    tick = 1'b0;
    wait_n(990);
    chk("timeout_early", int'(timeout), 0);
    wait_n(10);
    chk("timeout_set", int'(timeout), 1);
    chk("timeout_d_hold", int'(d_boost), 892);
    // e = 0: acc 230200 -> u 899
    update(2000, 899);

    // Second tick while waiting: overrun, single update (e = 10 -> u 899)
    chk("overrun_clear", int'(overrun), 0);
    pulse_tick();
    wait_n(10);
    pulse_tick();
    wait_n(10);
    chk("overrun_set", int'(overrun), 1);
    wait_n(40);
    v_meas  = 12'd1990;
    v_valid = 1'b1;
    q.push_back('{899, cyc + 4});
    wait_n(1);
    v_valid = 1'b0;
    wait_n(30);
    chk("timeout_sticky", int'(timeout), 1);
    chk("overrun_sticky", int'(overrun), 1);

    // Drop ce while the FSM is in INTEG
    pulse_tick();
    wait_n(90);
    v_meas  = 12'd1900;
    v_valid = 1'b1;
    wait_n(1);
    v_valid = 1'b0;
    wait_n(1);
    ce = 1'b0;
    wait_n(1);
    chk("ce_d_boost", int'(d_boost), 0);
    chk("ce_overrun", int'(overrun), 0);
    chk("ce_timeout", int'(timeout), 0);
    chk("ce_d_valid", int'(d_valid), 0);
    wait_n(5);
    ce = 1'b1;
    wait_n(5);
    chk("ce_resume_hold", int'(d_boost), 0);
    // Soft start: acc restarts at 0 -> same as the very first update
    update(1900, 7);

    // e = 2000 from zero duty
    ce = 1'b0;
    wait_n(2);
    ce = 1'b1;
    wait_n(3);
`ifdef BOOST_DUTY_SLEW_EN
    update(0, 8);
    update(0, 16);
    update(0, 24);
`else
    update(0, 140);
    update(0, 156);
    update(0, 171);
`endif

    wait_n(20);
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/boost_duty_ctrl.md
# boost_duty_ctrl

Closed-loop duty-cycle controller for the boost stage, directly upstream of the boost PWM block. On every rising edge of the boost block's `clk_int` control interrupt (period 60 µs), it takes one output-voltage sample and runs a saturating PI update. It then drives the 10-bit `d_boost` duty code that the boost PWM consumes. The block runs on the 100 MHz system clock.

## Interface
Parameters:
- `KP`, default 16: proportional gain, unsigned 8-bit, Q.FRAC
- `KI`, default 2: integral gain, unsigned 8-bit, Q.FRAC
- `FRAC`, default 8: fractional bits of the gain and accumulator scaling
- `D_MIN`, default 0: lowest duty code issued
- `D_MAX`, default 900: highest duty code issued (~88 % duty cap)
- `TIMEOUT`, default 1000: clk cycles allowed in WAIT_SAMPLE
- `SLEW_STEP`, default 8: maximum duty change per update (only with `DUTY_SLEW_EN`)

Ports:
- `clk` in 1: system clock, 10 ns
- `rst_n` in 1: asynchronous active-low reset
- `ce` in 1: enable; low forces soft-start state
- `tick` in 1: `clk_int` from the boost block, treated as asynchronous level
- `v_ref` in 12: voltage setpoint, ADC codes, unsigned
- `v_meas` in 12: measured output voltage, unsigned
- `v_valid` in 1: one-cycle strobe qualifying `v_meas`
- `d_boost` out 10: duty code to the boost PWM, registered
- `d_valid` out 1: one-cycle pulse when `d_boost` updates
- `overrun` out 1: sticky; a tick arrived while not IDLE
- `timeout` out 1: sticky; sample missing for `TIMEOUT` cycles

## Operation
- Reset values: all outputs 0; `acc` = `D_MIN`<<`FRAC`; FSM in IDLE.
- The `tick` input passes through a 2-FF synchronizer and a rising-edge detector, producing `tick_re`.
- FSM states: IDLE → WAIT_SAMPLE → ERR → INTEG → OUT → IDLE.
- IDLE: on `tick_re`, go to WAIT_SAMPLE and clear the wait counter.
- WAIT_SAMPLE: on `v_valid`, latch `v_meas` and go to ERR.
  - If the counter reaches `TIMEOUT` first, set `timeout` and return to IDLE.
  - On timeout, `d_boost` and `acc` are unchanged.
- ERR: compute `e = v_ref − v_meas`, 13-bit signed.
- INTEG: `acc += e*KI` (product is 21-bit signed, `acc` is 24-bit signed).
  - Anti-windup: clamp `acc` to [`D_MIN`<<`FRAC`, `D_MAX`<<`FRAC`].
- OUT: `u = (acc + e*KP) >>> FRAC`, arithmetic shift.
  - Clamp `u` to [`D_MIN`, `D_MAX`], register it into `d_boost`, pulse `d_valid`.
- `tick_re` in any state other than IDLE is ignored and sets `overrun`.
- `v_valid` outside WAIT_SAMPLE is ignored.
- `ce` low takes priority over all of the above. On the next clk it forces:
  - FSM to IDLE;
  - `d_boost` to 0;
  - `acc` to `D_MIN`<<`FRAC`;
  - `overrun` and `timeout` cleared.
  - Resuming `ce` therefore restarts from minimum duty (soft start).
- Asserting `rst_n` mid-cycle aborts immediately to the reset values; no partial `d_boost` update is ever output.

## Timing
- `tick` rising edge to FSM leaving IDLE: 3 clk (2 sync stages + edge register).
- `v_valid` at cycle N → `d_boost` and `d_valid` both change at the clock edge ending cycle N+3.
- `d_boost` is stable between updates. At most one update occurs per tick.
- Worst-case tick-to-update is 3 + `TIMEOUT` + 3 clk, which is well under the 6000-clk interrupt period.
- A `v_valid` arriving in the same cycle the timeout fires: timeout wins.

## Configuration
- `BOOST_DUTY_SLEW_EN` defined: in OUT, the clamped `u` is further limited to `d_boost` ± `SLEW_STEP` before being registered.
  - The limit applies after the `D_MIN`/`D_MAX` clamp, and the result still respects those bounds.
- Macro not defined: no slew limiting, and the `SLEW_STEP` parameter is unused.

## Structure
- Shared package `boost_pkg` holds:
  - the FSM state enum;
  - localparams for widths: ADC 12, error 13, product 21, acc 24, duty 10.
- Sub-module `pi_sat`: combinational multiply / add / arithmetic-shift / clamp used by INTEG and OUT.
  - Parameterized by gain, bounds and widths.
  - Instantiated twice: once with `KI` plus the acc bounds, once with `KP` plus the duty bounds.
- The synchronizer and edge detector stay inline.

## Test plan
- Reset, then `ce`=1, `v_ref`=2000. Each tick answered 100 clk later by `v_valid` with `v_meas`=1900:
  - e=100; first update gives `acc`=200, `u`=(200+1600)>>8=7;
  - `d_boost`=7 exactly 3 clk after `v_valid`, with `d_valid` high for 1 clk.
- Sustained e=+2000 → `d_boost` saturates at 900; `acc` stays at 900<<8. After e goes negative, `d_boost` falls on the very next update (no windup).
- Tick with no `v_valid` → `timeout`=1 after 1000 clk, `d_boost` unchanged, FSM back in IDLE. The next tick with a sample updates normally.
- Second tick pulse while in WAIT_SAMPLE → `overrun`=1, exactly one `d_valid` pulse.
- Drop `ce` mid-INTEG → next clk `d_boost`=0, FSM IDLE, flags cleared. Re-enable restarts from `D_MIN`.
- With `BOOST_DUTY_SLEW_EN`: e=+2000 from `d_boost`=0 → successive updates 8, 16, 24.
